opcode_sequencer: RTL and testbench
===================================

Name: opcode_sequencer

Overview:
- Sits between the IF/ID opcode field and the decode control unit. Supplies the 5-bit opcode the control unit decodes each cycle.
- Expands the two-part instructions CALL, RET and RTI into their two internal opcodes.
- Injects the two-cycle interrupt-entry sequence at an instruction boundary.
- Holds fetch (PC and IF/ID) while it injects internal opcodes. Squashes on flush. Obeys hazard stalls.

Parameters:
- OPW, 5, opcode width.
- INT_EDGE, 1, 1 = rising edge of int_req latches a pending interrupt; 0 = level (pending while int_req high).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- fetched_op  in  OPW  opcode field from the IF/ID register.
- fetched_valid  in  1  fetched_op holds a real instruction (0 = bubble).
- stall_in  in  1  hazard-unit stall; freezes the sequencer.
- flush_in  in  1  taken-branch flush of the decode stage.
- int_req  in  1  external interrupt request.
- op_out  out  OPW  registered opcode to the control unit.
- pc_hold  out  1  combinational; 1 = PC and IF/ID must not advance.
- busy  out  1  registered; 1 while a second part is still to be issued.
- int_ack  out  1  registered one-cycle pulse when 11111 is issued.
- illegal_op  out  1  registered one-cycle pulse; see Optional Feature.

Behaviour:
- Opcodes used:
  - NOP 00000.
  - CALL 11000 / 11001.
  - RET 11010 / 11011.
  - RTI 11100 / 11101.
  - INT1 11110, INT2 11111.
- Reset (async, while rst=1): state=IDLE, op_out=00000, busy=0, int_ack=0, illegal_op=0, pending=0. pc_hold=0.
- States: IDLE, CALL2, RET2, RTI2, INT2.
- All registers update on the rising edge of clk. op_out has 1-cycle latency, aligned with the ID stage.
- Priority per edge: flush_in > stall_in > pending interrupt (IDLE only) > fetched_op.
- flush_in=1:
  - op_out<=NOP, state<=IDLE, busy<=0, int_ack<=0.
  - pending is retained, so an aborted interrupt is taken later.
  - pc_hold=0.
- stall_in=1 (no flush): all registers hold; pc_hold=1.
- IDLE, pending=1:
  - op_out<=INT1, state<=INT2, busy<=1.
  - pc_hold=1 in this cycle; fetched_op is not consumed.
- IDLE, no pending, fetched_valid=0: op_out<=NOP.
- IDLE, fetched_valid=1, opcode CALL/RET/RTI first part:
  - op_out<=fetched_op, state<=CALL2/RET2/RTI2, busy<=1.
  - pc_hold=0; the instruction is consumed.
- IDLE, fetched_valid=1, opcode in 00000..10111: op_out<=fetched_op.
- IDLE, fetched_valid=1, fetched second-part/INT opcode (11001, 11011, 11101, 11110, 11111): illegal.
  - op_out<=NOP; the instruction is consumed.
- CALL2/RET2/RTI2:
  - pc_hold=1.
  - op_out<=11001/11011/11101, state<=IDLE, busy<=0.
  - A pending interrupt waits until IDLE.
- INT2:
  - pc_hold=1.
  - op_out<=11111, state<=IDLE, busy<=0, int_ack<=1, pending<=0.
- Pending set/clear:
  - Set by an int_req edge (INT_EDGE=1) or level (INT_EDGE=0).
  - A set and a clear in the same cycle: set wins.
- int_ack is 0 in every cycle other than the INT2 issue cycle. A stall in INT2 delays it.
- Interrupt during CALL2: the second part issues first, then INT1 on the next edge (no splitting of a pair).

Optional Feature:
- Macro: SEQ_ILLEGAL_TRAP_EN.
- Defined: illegal_op pulses 1 for one cycle, registered alongside the NOP substitution.
- Undefined: illegal_op tied to 0; illegal opcodes are silently replaced by NOP.

Decomposition:
- Shared package holds:
  - opcode localparams (OP_NOP, OP_CALL, OP_CALL2, OP_RET, OP_RET2, OP_RTI, OP_RTI2, OP_INT1, OP_INT2);
  - the sequencer state encoding (3 bits).
- The control unit consumes the same opcode constants.
- One sub-module: int_pending_latch (edge/level detect, pending flop, set-over-clear). Instantiated once.

Test Plan:
- Reset mid-sequence: rst pulse while in CALL2 -> op_out=00000, busy=0, pc_hold=0 immediately, without waiting for clk.
- CALL expansion: fetched_op=11000, then 01001 held -> op_out 11000, 11001, 01001 on consecutive edges; pc_hold=1 only in the middle cycle.
- Interrupt at boundary: int_req rise while IDLE with fetched 00100 -> op_out 11110, 11111, 00100; int_ack=1 in the cycle op_out=11111.
- Stall and flush: stall_in=1 for 3 cycles in RET2 -> op_out stays 11010, then 11011. Flush in INT2 -> op_out=00000, pending kept, INT1 reissued next IDLE cycle.
- Illegal opcode: fetched_op=11101 in IDLE -> op_out=00000; illegal_op=1 for one cycle with the macro, 0 without.

Source files
------------

// File: rtl/opcode_sequencer_pkg.sv
// Shared opcode constants and sequencer state encoding.
// Consumed by opcode_sequencer and by the decode control unit so both sides
// agree on the internal two-part opcodes and the interrupt-entry pair.
package opcode_sequencer_pkg;

  localparam int unsigned SEQ_OPW = 5;
  localparam int unsigned SEQ_STW = 3;

  localparam logic [SEQ_OPW-1:0] OP_NOP   = 5'b00000;
  localparam logic [SEQ_OPW-1:0] OP_CALL  = 5'b11000;
  localparam logic [SEQ_OPW-1:0] OP_CALL2 = 5'b11001;
  localparam logic [SEQ_OPW-1:0] OP_RET   = 5'b11010;
  localparam logic [SEQ_OPW-1:0] OP_RET2  = 5'b11011;
  localparam logic [SEQ_OPW-1:0] OP_RTI   = 5'b11100;
  localparam logic [SEQ_OPW-1:0] OP_RTI2  = 5'b11101;
  localparam logic [SEQ_OPW-1:0] OP_INT1  = 5'b11110;
  localparam logic [SEQ_OPW-1:0] OP_INT2  = 5'b11111;

  typedef enum logic [SEQ_STW-1:0] {
    ST_IDLE  = 3'd0,
    ST_CALL2 = 3'd1,
    ST_RET2  = 3'd2,
    ST_RTI2  = 3'd3,
    ST_INT2  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/opcode_sequencer_int.sv
// int_pending_latch: turns the external interrupt request into a sticky
// pending flag. INT_EDGE=1 sets on a rising edge of int_req, INT_EDGE=0 sets
// on every cycle int_req is high. A set and a clear in the same cycle: set wins.
// Ports:
//   clk, rst      clock, async active-high reset
//   int_req       external interrupt request
//   clr           clear request (interrupt entry completed)
//   pending       registered pending flag
module int_pending_latch #(
  parameter int unsigned INT_EDGE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic int_req,
  input  logic clr,
  output logic pending
);

  logic set;

  // Request qualifier: edge detector or plain level.
  if (INT_EDGE != 0) begin : g_edge
    logic req_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) req_q <= 1'b0;
      else     req_q <= int_req;
    end
    assign set = int_req & ~req_q;
  end else begin : g_level
    assign set = int_req;
  end

  // Pending flop with set-over-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      pending <= 1'b0;
    else if (set) pending <= 1'b1;
    else if (clr) pending <= 1'b0;
  end

endmodule

// File: rtl/opcode_sequencer.sv
// opcode_sequencer: supplies the opcode the decode control unit sees each
// cycle. Expands CALL/RET/RTI into their two internal opcodes, injects the
// INT1/INT2 entry pair at an instruction boundary, holds fetch while it
// injects, squashes on flush and freezes on hazard stall.
// Build option: define SEQ_ILLEGAL_TRAP_EN to pulse illegal_op when a
// second-part/INT opcode is fetched; otherwise illegal_op is tied low.
// Ports:
//   clk, rst       clock, async active-high reset
//   fetched_op     opcode field from IF/ID
//   fetched_valid  fetched_op is a real instruction
//   stall_in       hazard stall (freeze)
//   flush_in       taken-branch flush of decode
//   int_req        external interrupt request
//   op_out         registered opcode to the control unit
//   pc_hold        combinational: PC and IF/ID must not advance
//   busy           registered: a second part is still to be issued
//   int_ack        registered pulse when INT2 issues
//   illegal_op     registered pulse on an illegal fetched opcode
module opcode_sequencer
  import opcode_sequencer_pkg::*;
#(
  parameter int unsigned OPW      = 5,
  parameter int unsigned INT_EDGE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] fetched_op,
  input  logic           fetched_valid,
  input  logic           stall_in,
  input  logic           flush_in,
  input  logic           int_req,
  output logic [OPW-1:0] op_out,
  output logic           pc_hold,
  output logic           busy,
  output logic           int_ack,
  output logic           illegal_op
);

  seq_state_e     state_q, state_d;
  logic [OPW-1:0] op_d;
  logic           busy_d;
  logic           ack_d;
  logic           ill_d;
  logic           pending;
  logic           pend_clr;

  int_pending_latch #(
    .INT_EDGE (INT_EDGE)
  ) u_int_pending (
    .clk     (clk),
    .rst     (rst),
    .int_req (int_req),
    .clr     (pend_clr),
    .pending (pending)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_out     <= OPW'(OP_NOP);
      busy       <= 1'b0;
      int_ack    <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_out     <= op_d;
      busy       <= busy_d;
      int_ack    <= ack_d;
      illegal_op <= ill_d;
    end
  end

  // Next state, next outputs and fetch hold. Priority: flush > stall >
  // pending interrupt (IDLE only) > fetched opcode.
  always_comb begin
    state_d  = state_q;
    op_d     = op_out;
    busy_d   = busy;
    ack_d    = 1'b0;
    ill_d    = 1'b0;
    pend_clr = 1'b0;
    pc_hold  = 1'b0;

    if (flush_in) begin
      // Pending is untouched so an aborted interrupt entry is retried.
      state_d = ST_IDLE;
      op_d    = OPW'(OP_NOP);
      busy_d  = 1'b0;
    end else if (stall_in) begin
      pc_hold = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pending) begin
            // Fetched instruction stays in IF/ID until entry completes.
            pc_hold = 1'b1;
            op_d    = OPW'(OP_INT1);
            state_d = ST_INT2;
            busy_d  = 1'b1;
          end else if (!fetched_valid) begin
            op_d = OPW'(OP_NOP);
          end else begin
            case (fetched_op)
              OPW'(OP_CALL): begin
                op_d    = fetched_op;
                state_d = ST_CALL2;
                busy_d  = 1'b1;
              end
              OPW'(OP_RET): begin
                op_d    = fetched_op;
                state_d = ST_RET2;
                busy_d  = 1'b1;
              end
              OPW'(OP_RTI): begin
                op_d    = fetched_op;
                state_d = ST_RTI2;
                busy_d  = 1'b1;
              end
              OPW'(OP_CALL2), OPW'(OP_RET2), OPW'(OP_RTI2),
              OPW'(OP_INT1), OPW'(OP_INT2): begin
                // Internal-only opcodes are never legal from fetch.
                op_d = OPW'(OP_NOP);
`ifdef SEQ_ILLEGAL_TRAP_EN
                ill_d = 1'b1;
`endif
              end
              default: op_d = fetched_op;
            endcase
          end
        end
        ST_CALL2: begin
          pc_hold = 1'b1;
          op_d    = OPW'(OP_CALL2);
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
        ST_RET2: begin
          pc_hold = 1'b1;
          op_d    = OPW'(OP_RET2);
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
        ST_RTI2: begin
          pc_hold = 1'b1;
          op_d    = OPW'(OP_RTI2);
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
        ST_INT2: begin
          pc_hold  = 1'b1;
          op_d     = OPW'(OP_INT2);
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          ack_d    = 1'b1;
          pend_clr = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          op_d    = OPW'(OP_NOP);
          busy_d  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_opcode_sequencer.sv
// Directed bench for opcode_sequencer: reset, CALL expansion, interrupt
// entry, stall/flush interaction and illegal-opcode substitution.
module tb_opcode_sequencer;

  logic       clk;
  logic       rst;
  logic [4:0] fetched_op;
  logic       fetched_valid;
  logic       stall_in;
  logic       flush_in;
  logic       int_req;
  logic [4:0] op_out;
  logic       pc_hold;
  logic       busy;
  logic       int_ack;
  logic       illegal_op;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic exp_ill;

  opcode_sequencer #(
    .OPW      (5),
    .INT_EDGE (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetched_op    (fetched_op),
    .fetched_valid (fetched_valid),
    .stall_in      (stall_in),
    .flush_in      (flush_in),
    .int_req       (int_req),
    .op_out        (op_out),
    .pc_hold       (pc_hold),
    .busy          (busy),
    .int_ack       (int_ack),
    .illegal_op    (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs set afterwards are sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef SEQ_ILLEGAL_TRAP_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    rst = 1'b1; fetched_op = 5'b00000; fetched_valid = 1'b0;
    stall_in = 1'b0; flush_in = 1'b0; int_req = 1'b0;
    tick(); tick();
    check("rst_op",   32'(op_out), 32'h00);
    check("rst_busy", 32'(busy), 0);
    check("rst_hold", 32'(pc_hold), 0);
    check("rst_ack",  32'(int_ack), 0);
    check("rst_ill",  32'(illegal_op), 0);
    rst = 1'b0;

    // CALL expansion
    fetched_op = 5'b11000; fetched_valid = 1'b1;
    #1 check("call_hold0", 32'(pc_hold), 0);
    tick();
    check("call_op1",   32'(op_out), 32'h18);
    check("call_busy1", 32'(busy), 1);
    check("call_hold1", 32'(pc_hold), 1);
    fetched_op = 5'b01001;
    tick();
    check("call_op2",   32'(op_out), 32'h19);
    check("call_busy2", 32'(busy), 0);
    check("call_hold2", 32'(pc_hold), 0);
    tick();
    check("call_op3",   32'(op_out), 32'h09);
    check("call_hold3", 32'(pc_hold), 0);

    // Async reset while in CALL2
    fetched_op = 5'b11000;
    tick();
    check("mid_busy_pre", 32'(busy), 1);
    fetched_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_op",   32'(op_out), 32'h00);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_hold", 32'(pc_hold), 0);
    #1 rst = 1'b0;
    tick();

    // Interrupt at instruction boundary
    int_req = 1'b1;
    tick();
    check("int_pre_op",   32'(op_out), 32'h00);
    check("int_pre_hold", 32'(pc_hold), 1);
    int_req = 1'b0; fetched_op = 5'b00100; fetched_valid = 1'b1;
    tick();
    check("int_op1",  32'(op_out), 32'h1e);
    check("int_busy", 32'(busy), 1);
    check("int_ack1", 32'(int_ack), 0);
    tick();
    check("int_op2",   32'(op_out), 32'h1f);
    check("int_ack2",  32'(int_ack), 1);
    check("int_hold2", 32'(pc_hold), 0);
    tick();
    check("int_op3",  32'(op_out), 32'h04);
    check("int_ack3", 32'(int_ack), 0);

    // Stall in RET2
    fetched_op = 5'b11010;
    tick();
    check("ret_op1", 32'(op_out), 32'h1a);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ret_stall_op",   32'(op_out), 32'h1a);
      check("ret_stall_hold", 32'(pc_hold), 1);
    end
    stall_in = 1'b0;
    tick();
    check("ret_op2",  32'(op_out), 32'h1b);
    check("ret_busy", 32'(busy), 0);
    fetched_valid = 1'b0;

    // Flush in INT2, interrupt retried
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    tick();
    check("fl_int1", 32'(op_out), 32'h1e);
    flush_in = 1'b1;
    #1 check("fl_hold", 32'(pc_hold), 0);
    tick();
    check("fl_op",   32'(op_out), 32'h00);
    check("fl_busy", 32'(busy), 0);
    check("fl_ack",  32'(int_ack), 0);
    flush_in = 1'b0;
    #1 check("fl_pend_hold", 32'(pc_hold), 1);
    tick();
    check("fl_re_int1", 32'(op_out), 32'h1e);
    tick();
    check("fl_re_int2", 32'(op_out), 32'h1f);
    check("fl_re_ack",  32'(int_ack), 1);
    tick();
    check("fl_idle_op", 32'(op_out), 32'h00);
    check("fl_idle_ack", 32'(int_ack), 0);

    // Illegal opcode and legal boundary
    fetched_op = 5'b11101; fetched_valid = 1'b1;
    tick();
    check("ill_op",   32'(op_out), 32'h00);
    check("ill_flag", 32'(illegal_op), 32'(exp_ill));
    check("ill_hold", 32'(pc_hold), 0);
    fetched_op = 5'b10111;
    tick();
    check("leg_op",   32'(op_out), 32'h17);
    check("leg_flag", 32'(illegal_op), 0);
    fetched_op = 5'b11111;
    tick();
    check("ill2_op",   32'(op_out), 32'h00);
    check("ill2_flag", 32'(illegal_op), 32'(exp_ill));
    fetched_valid = 1'b0;
    tick();
    check("bubble_op", 32'(op_out), 32'h00);
    check("ill_clr",   32'(illegal_op), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
